// File: rtl/mem_stage.sv
// RV32I memory stage: turns loads/stores from EX into single-outstanding data-memory
// requests and forwards everything else to WB with one cycle of latency.
package rv32i_types;
  localparam logic [6:0] op_b_load  = 7'b0000011;
  localparam logic [6:0] op_b_store = 7'b0100011;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] rd_v;
    logic        regf_we;
    logic        commit;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] inst;
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic [4:0]  rs2_s;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] rd_v;
    logic        regf_we;
    logic        commit;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } mem_wb_reg_t;
endpackage

module mem_stage
  import rv32i_types::*;
(
  input  logic        clk,
  input  logic        rst,
  input  ex_mem_reg_t ex_mem_reg,
  output logic        mem_ready,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_rmask,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output mem_wb_reg_t mem_wb_reg,
  output logic        misalign
);

  // Handshake: ex_mem_reg is consumed on a rising edge only while mem_ready=1;
  // while mem_ready=0 upstream must hold its register unchanged.
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  ex_mem_reg_t req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  rmask_q, rmask_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  mem_wb_reg_t wb_q, wb_d;
  logic        mis_q, mis_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] i_imm, s_imm, ea;
  logic        is_load, is_store, is_mem;
  logic [3:0]  acc_mask;
  logic        acc_ok;
  logic [31:0] ld_shifted, ld_value;

  assign opcode   = ex_mem_reg.inst[6:0];
  assign funct3   = ex_mem_reg.inst[14:12];
  assign i_imm    = {{20{ex_mem_reg.inst[31]}}, ex_mem_reg.inst[31:20]};
  assign s_imm    = {{20{ex_mem_reg.inst[31]}}, ex_mem_reg.inst[31:25], ex_mem_reg.inst[11:7]};
  assign is_load  = (opcode == op_b_load);
  assign is_store = (opcode == op_b_store);
  assign is_mem   = is_load || is_store;
  assign ea       = ex_mem_reg.rs1_v + (is_store ? s_imm : i_imm);

  // Unsigned load widths only exist for loads; anything else is a bad access.
  always_comb begin
    acc_mask = 4'b0000;
    acc_ok   = 1'b0;
    case (funct3)
      3'b000: begin
        acc_mask = 4'b0001 << ea[1:0];
        acc_ok   = 1'b1;
      end
      3'b100: begin
        acc_mask = 4'b0001 << ea[1:0];
        acc_ok   = is_load;
      end
      3'b001: begin
        acc_mask = 4'b0011 << ea[1:0];
        acc_ok   = !ea[0];
      end
      3'b101: begin
        acc_mask = 4'b0011 << ea[1:0];
        acc_ok   = is_load && !ea[0];
      end
      3'b010: begin
        acc_mask = 4'b1111;
        acc_ok   = (ea[1:0] == 2'b00);
      end
      default: begin
        acc_mask = 4'b0000;
        acc_ok   = 1'b0;
      end
    endcase
  end

  assign ld_shifted = dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (req_q.inst[14:12])
      3'b000:  ld_value = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_value = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_value = {24'b0, ld_shifted[7:0]};
      3'b101:  ld_value = {16'b0, ld_shifted[15:0]};
      default: ld_value = ld_shifted;
    endcase
  end

  function automatic mem_wb_reg_t to_wb(input ex_mem_reg_t e);
    mem_wb_reg_t w;
    w           = '0;
    w.pc        = e.pc;
    w.pc_next   = e.pc_next;
    w.inst      = e.inst;
    w.rd_s      = e.rd_s;
    w.rs1_s     = e.rs1_s;
    w.rs2_s     = e.rs2_s;
    w.rs1_v     = e.rs1_v;
    w.rs2_v     = e.rs2_v;
    w.rd_v      = e.rd_v;
    w.regf_we   = e.regf_we && (e.rd_s != 5'd0);
    w.commit    = 1'b1;
    return w;
  endfunction

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    rmask_d     = rmask_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    off_d       = off_q;
    wb_d        = wb_q;
    wb_d.commit = 1'b0;
    mis_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (ex_mem_reg.commit) begin
          if (is_mem && acc_ok) begin
            state_d = WAIT;
            req_d   = ex_mem_reg;
            addr_d  = {ea[31:2], 2'b00};
            rmask_d = is_load ? acc_mask : 4'b0000;
            wmask_d = is_store ? acc_mask : 4'b0000;
            wdata_d = is_store ? (ex_mem_reg.rs2_v << {ea[1:0], 3'b000}) : 32'h0;
            off_d   = ea[1:0];
          end else begin
            // Bad accesses still retire, but never write the register file.
            wb_d          = to_wb(ex_mem_reg);
            wb_d.mem_addr = {ea[31:2], 2'b00};
            if (is_mem) begin
              wb_d.regf_we = 1'b0;
              mis_d        = 1'b1;
            end
          end
        end
      end
      WAIT: begin
        if (dmem_resp) begin
          wb_d           = to_wb(req_q);
          wb_d.mem_addr  = addr_q;
          wb_d.mem_rmask = rmask_q;
          wb_d.mem_wmask = wmask_q;
          wb_d.mem_rdata = dmem_rdata;
          wb_d.mem_wdata = wdata_q;
          if (rmask_q != 4'b0000) begin
            wb_d.rd_v    = ld_value;
            wb_d.regf_we = (req_q.rd_s != 5'd0);
          end else begin
            wb_d.rd_v    = 32'h0;
            wb_d.regf_we = 1'b0;
          end
          state_d = IDLE;
          rmask_d = 4'b0000;
          wmask_d = 4'b0000;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      off_q   <= '0;
      wb_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      off_q   <= off_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
    end
  end

  assign mem_ready  = (state_q == IDLE);
  assign dmem_addr  = addr_q;
  assign dmem_rmask = (state_q == WAIT) ? rmask_q : 4'b0000;
  assign dmem_wmask = (state_q == WAIT) ? wmask_q : 4'b0000;
  assign dmem_wdata = wdata_q;
  assign mem_wb_reg = wb_q;
  assign misalign   = mis_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-instruction vectors with
// hand-computed results, plus reset and idle corner sequences.
module tb_mem_stage;
  import rv32i_types::*;

  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  logic        clk;
  logic        rst;
  ex_mem_reg_t ex_mem_reg;
  logic        mem_ready;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  mem_wb_reg_t mem_wb_reg;
  logic        misalign;

  int total;
  int bad;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] rs1_v;
    logic [31:0] rs2_v;
    logic [31:0] rd_v_in;
    logic [4:0]  rd_s;
    logic        we_in;
    int          delay;
    logic [31:0] rdata;
    logic        is_mem;
    logic        exp_mis;
    logic [31:0] exp_addr;
    logic [3:0]  exp_rmask;
    logic [3:0]  exp_wmask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd_v;
    logic        exp_we;
  } vec_t;

  vec_t vecs[14];

  mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .ex_mem_reg (ex_mem_reg),
    .mem_ready  (mem_ready),
    .dmem_addr  (dmem_addr),
    .dmem_rmask (dmem_rmask),
    .dmem_wmask (dmem_wmask),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_resp  (dmem_resp),
    .mem_wb_reg (mem_wb_reg),
    .misalign   (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, 5'd1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] inst, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] rdvin, input logic [4:0] rd,
                              input logic we, input int dly, input logic [31:0] rdata,
                              input logic mem, input logic mis, input logic [31:0] addr,
                              input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] wd,
                              input logic [31:0] rdv, input logic ewe);
    vec_t v;
    v.name = n; v.inst = inst; v.rs1_v = rs1; v.rs2_v = rs2; v.rd_v_in = rdvin;
    v.rd_s = rd; v.we_in = we; v.delay = dly; v.rdata = rdata; v.is_mem = mem;
    v.exp_mis = mis; v.exp_addr = addr; v.exp_rmask = rm; v.exp_wmask = wm;
    v.exp_wdata = wd; v.exp_rd_v = rdv; v.exp_we = ewe;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] pc;
    pc                 = 32'h100 + 32'(idx) * 4;
    ex_mem_reg         = '0;
    ex_mem_reg.pc      = pc;
    ex_mem_reg.pc_next = pc + 4;
    ex_mem_reg.inst    = v.inst;
    ex_mem_reg.rd_s    = v.rd_s;
    ex_mem_reg.rs1_s   = 5'd1;
    ex_mem_reg.rs2_s   = 5'd2;
    ex_mem_reg.rs1_v   = v.rs1_v;
    ex_mem_reg.rs2_v   = v.rs2_v;
    ex_mem_reg.rd_v    = v.rd_v_in;
    ex_mem_reg.regf_we = v.we_in;
    ex_mem_reg.commit  = 1'b1;
    check({v.name, ".ready_in"}, 32'(mem_ready), 32'd1);
    @(posedge clk); #1;
    ex_mem_reg.commit = 1'b0;
    if (v.is_mem) begin
      for (int c = 0; c < v.delay; c++) begin
        check({v.name, ".ready_wait"}, 32'(mem_ready), 32'd0);
        check({v.name, ".dmem_addr"}, dmem_addr, v.exp_addr);
        check({v.name, ".dmem_rmask"}, 32'(dmem_rmask), 32'(v.exp_rmask));
        check({v.name, ".dmem_wmask"}, 32'(dmem_wmask), 32'(v.exp_wmask));
        check({v.name, ".dmem_wdata"}, dmem_wdata, v.exp_wdata);
        check({v.name, ".commit_wait"}, 32'(mem_wb_reg.commit), 32'd0);
        if (c == v.delay - 1) begin
          dmem_resp  = 1'b1;
          dmem_rdata = v.rdata;
        end
        @(posedge clk); #1;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
      end
      check({v.name, ".commit"}, 32'(mem_wb_reg.commit), 32'd1);
      check({v.name, ".rd_v"}, mem_wb_reg.rd_v, v.exp_rd_v);
      check({v.name, ".regf_we"}, 32'(mem_wb_reg.regf_we), 32'(v.exp_we));
      check({v.name, ".mem_addr"}, mem_wb_reg.mem_addr, v.exp_addr);
      check({v.name, ".mem_rmask"}, 32'(mem_wb_reg.mem_rmask), 32'(v.exp_rmask));
      check({v.name, ".mem_wmask"}, 32'(mem_wb_reg.mem_wmask), 32'(v.exp_wmask));
      check({v.name, ".mem_wdata"}, mem_wb_reg.mem_wdata, v.exp_wdata);
      if (v.exp_rmask != 4'b0000)
        check({v.name, ".mem_rdata"}, mem_wb_reg.mem_rdata, v.rdata);
      check({v.name, ".misalign"}, 32'(misalign), 32'd0);
      check({v.name, ".ready_done"}, 32'(mem_ready), 32'd1);
      check({v.name, ".rmask_done"}, 32'(dmem_rmask), 32'd0);
      check({v.name, ".pc"}, mem_wb_reg.pc, pc);
    end else begin
      check({v.name, ".commit"}, 32'(mem_wb_reg.commit), 32'd1);
      check({v.name, ".rd_v"}, mem_wb_reg.rd_v, v.exp_rd_v);
      check({v.name, ".regf_we"}, 32'(mem_wb_reg.regf_we), 32'(v.exp_we));
      check({v.name, ".misalign"}, 32'(misalign), 32'(v.exp_mis));
      check({v.name, ".ready"}, 32'(mem_ready), 32'd1);
      check({v.name, ".mem_masks"}, 32'({mem_wb_reg.mem_rmask, mem_wb_reg.mem_wmask}), 32'd0);
      check({v.name, ".dmem_masks"}, 32'({dmem_rmask, dmem_wmask}), 32'd0);
      check({v.name, ".pc"}, mem_wb_reg.pc, pc);
      @(posedge clk); #1;
      check({v.name, ".misalign_pulse"}, 32'(misalign), 32'd0);
      check({v.name, ".commit_once"}, 32'(mem_wb_reg.commit), 32'd0);
    end
  endtask

  initial begin
    total      = 0;
    bad        = 0;
    rst        = 1'b0;
    ex_mem_reg = '0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;

    //      name       inst                              rs1           rs2           rd_v_in      rd  we dly rdata         mem mis addr          rm       wm       wdata         rd_v          we
    vecs[0]  = mk("addi",   enc_i(12'h010, 3'b000, 5'd5, OP_IMM),  32'h0,        32'h0,        32'h10, 5'd5, 1, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h10,       1);
    vecs[1]  = mk("lb",     enc_i(12'h000, 3'b000, 5'd7, OP_LOAD), 32'h1003,     32'h0,        32'h0,  5'd7, 1, 3, 32'h80FFFFFF, 1, 0, 32'h1000,     4'b1000, 4'b0000, 32'h0,        32'hFFFFFF80, 1);
    vecs[2]  = mk("sh",     enc_s(12'h000, 3'b001),                32'h2002,     32'h1234ABCD, 32'h77, 5'd0, 0, 1, 32'h0,        1, 0, 32'h2000,     4'b0000, 4'b1100, 32'hABCD0000, 32'h0,        0);
    vecs[3]  = mk("lw_mis", enc_i(12'h000, 3'b010, 5'd8, OP_LOAD), 32'h3001,     32'h0,        32'h55, 5'd8, 1, 0, 32'h0,        0, 1, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h55,       0);
    vecs[4]  = mk("lhu_x0", enc_i(12'h000, 3'b101, 5'd0, OP_LOAD), 32'h4002,     32'h0,        32'h0,  5'd0, 1, 2, 32'h80010000, 1, 0, 32'h4000,     4'b1100, 4'b0000, 32'h0,        32'h00008001, 0);
    vecs[5]  = mk("lbu",    enc_i(12'h005, 3'b100, 5'd9, OP_LOAD), 32'h5000,     32'h0,        32'h0,  5'd9, 1, 2, 32'h0000AB00, 1, 0, 32'h5004,     4'b0010, 4'b0000, 32'h0,        32'h000000AB, 1);
    vecs[6]  = mk("lh",     enc_i(12'h002, 3'b001, 5'd10, OP_LOAD),32'h6000,     32'h0,        32'h0,  5'd10,1, 1, 32'h80000000, 1, 0, 32'h6000,     4'b1100, 4'b0000, 32'h0,        32'hFFFF8000, 1);
    vecs[7]  = mk("lw",     enc_i(12'h004, 3'b010, 5'd11, OP_LOAD),32'h7000,     32'h0,        32'h0,  5'd11,1, 1, 32'hDEADBEEF, 1, 0, 32'h7004,     4'b1111, 4'b0000, 32'h0,        32'hDEADBEEF, 1);
    vecs[8]  = mk("sb_neg", enc_s(12'hFFF, 3'b000),                32'h8000,     32'h000000A5, 32'h0,  5'd3, 1, 2, 32'h0,        1, 0, 32'h7FFC,     4'b0000, 4'b1000, 32'hA5000000, 32'h0,        0);
    vecs[9]  = mk("sw",     enc_s(12'h008, 3'b010),                32'h9000,     32'hCAFEF00D, 32'h0,  5'd0, 0, 1, 32'h0,        1, 0, 32'h9008,     4'b0000, 4'b1111, 32'hCAFEF00D, 32'h0,        0);
    vecs[10] = mk("sh_mis", enc_s(12'h000, 3'b001),                32'hA001,     32'h1,        32'h0,  5'd0, 0, 0, 32'h0,        0, 1, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h0,        0);
    vecs[11] = mk("ld_f3",  enc_i(12'h000, 3'b011, 5'd12, OP_LOAD),32'hB000,     32'h0,        32'h99, 5'd12,1, 0, 32'h0,        0, 1, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h99,       0);
    vecs[12] = mk("lw_wrap",enc_i(12'h008, 3'b010, 5'd13, OP_LOAD),32'hFFFFFFFC, 32'h0,        32'h0,  5'd13,1, 1, 32'h12345678, 1, 0, 32'h4,        4'b1111, 4'b0000, 32'h0,        32'h12345678, 1);
    vecs[13] = mk("addi_x0",enc_i(12'h010, 3'b000, 5'd0, OP_IMM),  32'h0,        32'h0,        32'h10, 5'd0, 1, 0, 32'h0,        0, 0, 32'h0,        4'b0000, 4'b0000, 32'h0,        32'h10,       0);

    #12;
    check("rst.commit", 32'(mem_wb_reg.commit), 32'd0);
    check("rst.wb_all", 32'(|mem_wb_reg), 32'd0);
    check("rst.misalign", 32'(misalign), 32'd0);
    check("rst.ready", 32'(mem_ready), 32'd1);
    check("rst.masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    ex_mem_reg        = '0;
    ex_mem_reg.inst   = enc_i(12'h000, 3'b010, 5'd4, OP_LOAD);
    ex_mem_reg.rd_s   = 5'd4;
    ex_mem_reg.commit = 1'b0;
    @(posedge clk); #1;
    check("idle_nocommit.commit", 32'(mem_wb_reg.commit), 32'd0);
    check("idle_nocommit.rmask", 32'(dmem_rmask), 32'd0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    dmem_resp  = 1'b0;
    check("idle_resp.commit", 32'(mem_wb_reg.commit), 32'd0);
    check("idle_resp.ready", 32'(mem_ready), 32'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    ex_mem_reg        = '0;
    ex_mem_reg.inst   = enc_i(12'h000, 3'b010, 5'd3, OP_LOAD);
    ex_mem_reg.rd_s   = 5'd3;
    ex_mem_reg.rs1_v  = 32'hC000;
    ex_mem_reg.commit = 1'b1;
    @(posedge clk); #1;
    ex_mem_reg.commit = 1'b0;
    check("rstwait.rmask_before", 32'(dmem_rmask), 32'hF);
    #2 rst = 1'b0;
    #1;
    check("rstwait.rmask", 32'(dmem_rmask), 32'd0);
    check("rstwait.wmask", 32'(dmem_wmask), 32'd0);
    check("rstwait.ready", 32'(mem_ready), 32'd1);
    check("rstwait.commit", 32'(mem_wb_reg.commit), 32'd0);
    #3 rst = 1'b1;
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h11223344;
    @(posedge clk); #1;
    dmem_resp  = 1'b0;
    check("rstwait.late_resp_commit", 32'(mem_wb_reg.commit), 32'd0);
    check("rstwait.late_resp_ready", 32'(mem_ready), 32'd1);
    run_vec(vecs[0], 20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
